// File: rtl/alu_serial_rx.sv
// -----------------------------------------------------------------------------
// alu_serial_rx
//   Serial command deserializer in front of the ALU core. Each 11-bit word is
//   start(0), type, 8 payload bits MSB first, stop(1). Data words (type 0) are
//   shifted MSB-first into a 64-bit {B,A} shadow. A control word (type 1,
//   payload {0, op[2:0], crc[3:0]}) closes the frame. The frame is then checked
//   for framing, CRC4 and opcode, and handed to the core over valid/ready.
//
// Optional feature:
//   ALU_RX_TIMEOUT_EN - when defined, a partially received frame that stays
//   idle for more than TIMEOUT_CYCLES cycles is aborted. It is reported with
//   out_err = 100.
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   sin        serial input, idle high, one bit per clock
//   out_ready  core accepts the presented command
//   out_valid  command/flags valid, held until accepted
//   out_b      operand B (first four data bytes)
//   out_a      operand A (next four data bytes)
//   out_op     opcode
//   out_err    {ERR_DATA, ERR_CRC, ERR_OP}, at most one bit set
//   overrun    one-cycle pulse when a completed frame is dropped
// -----------------------------------------------------------------------------
module alu_serial_rx #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sin,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_b,
  output logic [31:0] out_a,
  output logic [2:0]  out_op,
  output logic [2:0]  out_err,
  output logic        overrun
);

  typedef enum logic [2:0] {S_IDLE, S_TYPE, S_DATA, S_STOP, S_CHECK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        type_q, type_d;
  logic [63:0] shadow_q, shadow_d;
  logic [3:0]  word_cnt_q, word_cnt_d;
  logic        stop_err_q, stop_err_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  crc_q, crc_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_b_q, out_b_d;
  logic [31:0] out_a_q, out_a_d;
  logic [2:0]  out_op_q, out_op_d;
  logic [2:0]  out_err_q, out_err_d;
  logic        overrun_q, overrun_d;

  logic        timeout;   // abort request raised while idling inside a frame
  logic        abort_q;   // current frame was ended by the idle timeout

`ifdef ALU_RX_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              abort_d;

  // The counter only advances while idling after at least one data word.
  // Any non-idle cycle (start bit included) returns it to zero.
  always_comb begin
    idle_cnt_d = '0;
    abort_d    = abort_q;
    timeout    = 1'b0;
    if (state_q == S_IDLE && word_cnt_q != 4'd0 && sin) begin
      if (idle_cnt_q == IDLE_MAX) begin
        timeout = 1'b1;
        abort_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + 1'b1;
      end
    end
    if (state_q == S_CHECK) abort_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      abort_q    <= abort_d;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign timeout        = 1'b0;
  assign abort_q        = 1'b0;
`endif

  // CRC4 (x^4 + x + 1, init 0) over {B, A, 1'b1, op}, MSB first, unrolled
  // as a chain of single-bit LFSR steps.
  logic [67:0] crc_msg;
  logic [3:0]  crc_chain [0:68];

  assign crc_msg      = {shadow_q, 1'b1, op_q};
  assign crc_chain[0] = 4'b0000;

  for (genvar gi = 0; gi < 68; gi++) begin : g_crc
    logic fb;
    assign fb             = crc_chain[gi][3] ^ crc_msg[67-gi];
    assign crc_chain[gi+1] = {crc_chain[gi][2:0], 1'b0} ^ {2'b00, fb, fb};
  end

  logic       err_data, err_crc, err_op, accept;
  logic [2:0] frame_err;

  assign err_data = (word_cnt_q != 4'd8) || stop_err_q || abort_q;
  assign err_crc  = (crc_chain[68] != crc_q);
  assign err_op   = !((op_q == 3'b000) || (op_q == 3'b001) ||
                      (op_q == 3'b100) || (op_q == 3'b101));
  assign accept   = out_valid_q && out_ready;

  always_comb begin
    frame_err = 3'b000;
    if (err_data)     frame_err = 3'b100;
    else if (err_crc) frame_err = 3'b010;
    else if (err_op)  frame_err = 3'b001;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic. CHECK also samples sin so a start bit right after a
  // control word's stop bit is not lost.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!sin) state_d = S_TYPE;
               else if (timeout) state_d = S_CHECK;
      S_TYPE:  state_d = S_DATA;
      S_DATA:  if (bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  state_d = type_q ? S_CHECK : S_IDLE;
      S_CHECK: state_d = sin ? S_IDLE : S_TYPE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    byte_d      = byte_q;
    type_d      = type_q;
    shadow_d    = shadow_q;
    word_cnt_d  = word_cnt_q;
    stop_err_d  = stop_err_q;
    op_d        = op_q;
    crc_d       = crc_q;
    out_valid_d = out_valid_q;
    out_b_d     = out_b_q;
    out_a_d     = out_a_q;
    out_op_d    = out_op_q;
    out_err_d   = out_err_q;
    overrun_d   = 1'b0;

    if (accept) out_valid_d = 1'b0;

    case (state_q)
      S_TYPE: begin
        type_d    = sin;
        bit_cnt_d = 3'd0;
      end
      S_DATA: begin
        byte_d    = {byte_q[6:0], sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      S_STOP: begin
        if (!sin) stop_err_d = 1'b1;
        if (type_q) begin
          op_d  = byte_q[6:4];
          crc_d = byte_q[3:0];
        end else begin
          shadow_d = {shadow_q[55:0], byte_q};
          if (word_cnt_q != 4'd9) word_cnt_d = word_cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        // A held, unaccepted command wins; the new frame is dropped.
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_b_d     = shadow_q[63:32];
          out_a_d     = shadow_q[31:0];
          out_op_d    = op_q;
          out_err_d   = frame_err;
        end else begin
          overrun_d = 1'b1;
        end
        shadow_d   = '0;
        word_cnt_d = 4'd0;
        stop_err_d = 1'b0;
        op_d       = 3'b000;
        crc_d      = 4'b0000;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q   <= 3'd0;
      byte_q      <= 8'h00;
      type_q      <= 1'b0;
      shadow_q    <= '0;
      word_cnt_q  <= 4'd0;
      stop_err_q  <= 1'b0;
      op_q        <= 3'b000;
      crc_q       <= 4'b0000;
      out_valid_q <= 1'b0;
      out_b_q     <= '0;
      out_a_q     <= '0;
      out_op_q    <= 3'b000;
      out_err_q   <= 3'b000;
      overrun_q   <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      byte_q      <= byte_d;
      type_q      <= type_d;
      shadow_q    <= shadow_d;
      word_cnt_q  <= word_cnt_d;
      stop_err_q  <= stop_err_d;
      op_q        <= op_d;
      crc_q       <= crc_d;
      out_valid_q <= out_valid_d;
      out_b_q     <= out_b_d;
      out_a_q     <= out_a_d;
      out_op_q    <= out_op_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_b     = out_b_q;
  assign out_a     = out_a_q;
  assign out_op    = out_op_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_alu_serial_rx
//   Self-checking bench for alu_serial_rx. Frames are described at byte level
//   and expectations come from a word-level reference model (shift of bytes
//   into a 64-bit value, CRC by polynomial long division, error priority).
//   Table vectors, directed multi-cycle sequences and random frames.
//   Define ALU_RX_TIMEOUT_EN for both DUT and bench to test the idle timeout.
// -----------------------------------------------------------------------------
module tb_alu_serial_rx;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sin = 1'b1;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_b, out_a;
  logic [2:0]  out_op, out_err;
  logic        overrun;

  alu_serial_rx #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sin(sin), .out_ready(out_ready),
    .out_valid(out_valid), .out_b(out_b), .out_a(out_a), .out_op(out_op),
    .out_err(out_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] b;
    logic [31:0] a;
    logic [2:0]  op;
    logic [2:0]  err;
  } res_t;

  typedef struct {
    logic [63:0] ba;
    logic [2:0]  op;
    logic [3:0]  flip;
    int          n;
    int          bad;
    logic [2:0]  exp_err;
  } vec_t;

  res_t acc_q[$];
  res_t exp_q[$];
  int   ovr_cnt = 0;
  int   tests = 0;
  int   fails = 0;

  // Accepted commands and overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) acc_q.push_back({out_b, out_a, out_op, out_err});
      if (overrun) ovr_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [69:0] act, input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sin = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    sin = b;
    tick();
  endtask

  task automatic send_word(input logic t, input logic [7:0] p, input logic stop);
    send_bit(1'b0);
    send_bit(t);
    for (int i = 7; i >= 0; i--) send_bit(p[i]);
    send_bit(stop);
  endtask

  function automatic logic [3:0] ref_crc(input logic [67:0] m);
    logic [71:0] r;
    r = {m, 4'b0000};
    for (int i = 71; i >= 4; i--)
      if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
    return r[3:0];
  endfunction

  function automatic logic [7:0] byte_of(input logic [63:0] ba, input int i);
    if (i < 8) return ba[63-8*i -: 8];
    return 8'hA5;
  endfunction

  // n data words (bytes of ba, then 0xA5 fillers), control word with the
  // CRC of the intended {ba, op} xor flip. bad = index of word with a 0
  // stop bit (n = control word), -1 for none.
  task automatic send_frame(input logic [63:0] ba, input logic [2:0] op,
                            input logic [3:0] flip, input int n, input int bad);
    for (int i = 0; i < n; i++) send_word(1'b0, byte_of(ba, i), bad != i);
    send_word(1'b1, {1'b0, op, ref_crc({ba, 1'b1, op}) ^ flip}, bad != n);
    sin = 1'b1;
  endtask

  function automatic res_t model(input logic [63:0] ba, input logic [2:0] op,
                                 input logic [3:0] flip, input int n, input int bad);
    res_t r;
    logic [63:0] sh;
    logic [3:0]  rx_crc;
    bit data_bad, crc_bad, op_bad;
    sh = '0;
    for (int i = 0; i < n; i++) sh = (sh << 8) | {56'd0, byte_of(ba, i)};
    rx_crc   = ref_crc({ba, 1'b1, op}) ^ flip;
    data_bad = (n != 8) || (bad >= 0);
    crc_bad  = rx_crc != ref_crc({sh, 1'b1, op});
    op_bad   = !(op == 3'd0 || op == 3'd1 || op == 3'd4 || op == 3'd5);
    r.b  = sh[63:32];
    r.a  = sh[31:0];
    r.op = op;
    r.err = data_bad ? 3'b100 : crc_bad ? 3'b010 : op_bad ? 3'b001 : 3'b000;
    return r;
  endfunction

  task automatic get_result(input string name, output res_t r, output bit ok);
    r  = '0;
    ok = 1'b0;
    for (int k = 0; k < 60 && acc_q.size() == 0; k++) tick();
    if (acc_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: no accepted command within 60 cycles, expected one", name);
    end else begin
      r  = acc_q.pop_front();
      ok = 1'b1;
    end
  endtask

  initial begin
    vec_t tbl[11];
    res_t r, m, m2;
    bit   ok;
    int   ovr_base, n_acc;
    logic [63:0] ba;
    logic [2:0]  op;
    logic [3:0]  flip;
    int          n, bad;

    tbl[0]  = '{64'h00000005_00000003, 3'b100, 4'h0, 8, -1, 3'b000};
    tbl[1]  = '{64'h00000005_00000003, 3'b100, 4'h1, 8, -1, 3'b010};
    tbl[2]  = '{64'h00000005_00000003, 3'b111, 4'h0, 8, -1, 3'b001};
    tbl[3]  = '{64'h11223344_55667788, 3'b000, 4'h0, 7, -1, 3'b100};
    tbl[4]  = '{64'h11223344_55667788, 3'b000, 4'h0, 9, -1, 3'b100};
    tbl[5]  = '{64'hFFFFFFFF_12345678, 3'b001, 4'h0, 8, -1, 3'b000};
    tbl[6]  = '{64'hDEADBEEF_CAFEF00D, 3'b101, 4'h0, 8,  3, 3'b100};
    tbl[7]  = '{64'h0BADF00D_00000001, 3'b010, 4'h8, 8, -1, 3'b010};
    tbl[8]  = '{64'h80000000_00000000, 3'b000, 4'h0, 8, -1, 3'b000};
    tbl[9]  = '{64'h01020304_05060708, 3'b110, 4'h3, 7, -1, 3'b100};
    tbl[10] = '{64'hA5A5A5A5_5A5A5A5A, 3'b100, 4'h0, 8,  8, 3'b100};

    // Reset state
    repeat (3) tick();
    check("rst_valid", 70'(out_valid), 70'(0));
    check("rst_b", 70'(out_b), 70'(0));
    check("rst_a", 70'(out_a), 70'(0));
    check("rst_op", 70'(out_op), 70'(0));
    check("rst_err", 70'(out_err), 70'(0));
    check("rst_overrun", 70'(overrun), 70'(0));
    rst_n = 1'b1;
    idle(2);

    // Latency and handshake on the basic frame
    out_ready = 1'b0;
    send_frame(64'h00000005_00000003, 3'b100, 4'h0, 8, -1);
    check("lat_check_cycle", 70'(out_valid), 70'(0));
    tick();
    check("lat_valid", 70'(out_valid), 70'(1));
    m = model(64'h00000005_00000003, 3'b100, 4'h0, 8, -1);
    check("lat_outputs", 70'({out_b, out_a, out_op, out_err}), 70'(m));
    tick();
    check("hold_valid", 70'(out_valid), 70'(1));
    out_ready = 1'b1;
    tick();
    check("release_valid", 70'(out_valid), 70'(0));
    get_result("lat_pop", r, ok);
    if (ok) check("lat_accepted", 70'(r), 70'(m));

    // Table vectors
    for (int i = 0; i < 11; i++) begin
      send_frame(tbl[i].ba, tbl[i].op, tbl[i].flip, tbl[i].n, tbl[i].bad);
      get_result($sformatf("vec%0d_pop", i), r, ok);
      if (ok) begin
        m = model(tbl[i].ba, tbl[i].op, tbl[i].flip, tbl[i].n, tbl[i].bad);
        $display("[TB] vec %0d b=%h a=%h op=%b err=%b", i, r.b, r.a, r.op, r.err);
        check($sformatf("vec%0d_err", i), 70'(r.err), 70'(tbl[i].exp_err));
        check($sformatf("vec%0d_b", i), 70'(r.b), 70'(m.b));
        check($sformatf("vec%0d_a", i), 70'(r.a), 70'(m.a));
        check($sformatf("vec%0d_op", i), 70'(r.op), 70'(m.op));
      end
      idle(2);
    end

    // Overrun: second frame dropped while the first is held
    ovr_base  = ovr_cnt;
    out_ready = 1'b0;
    m  = model(64'h00000010_00000020, 3'b000, 4'h0, 8, -1);
    send_frame(64'h00000010_00000020, 3'b000, 4'h0, 8, -1);
    send_frame(64'h99999999_77777777, 3'b101, 4'h0, 8, -1);
    tick();
    check("ovr_pulse", 70'(overrun), 70'(1));
    check("ovr_valid_held", 70'(out_valid), 70'(1));
    check("ovr_outputs_held", 70'({out_b, out_a, out_op, out_err}), 70'(m));
    tick();
    check("ovr_pulse_end", 70'(overrun), 70'(0));
    check("ovr_count", 70'(ovr_cnt - ovr_base), 70'(1));
    out_ready = 1'b1;
    tick();
    check("ovr_release", 70'(out_valid), 70'(0));
    get_result("ovr_pop", r, ok);
    if (ok) check("ovr_accepted", 70'(r), 70'(m));
    idle(3);
    check("ovr_no_extra", 70'(acc_q.size()), 70'(0));
    $display("[TB] overrun sequence done, pulses=%0d", ovr_cnt - ovr_base);

    // Acceptance in the CHECK cycle loads the new frame
    ovr_base  = ovr_cnt;
    out_ready = 1'b0;
    m  = model(64'h12345678_9ABCDEF0, 3'b001, 4'h0, 8, -1);
    m2 = model(64'h0F0F0F0F_F0F0F0F0, 3'b100, 4'h0, 8, -1);
    send_frame(64'h12345678_9ABCDEF0, 3'b001, 4'h0, 8, -1);
    send_frame(64'h0F0F0F0F_F0F0F0F0, 3'b100, 4'h0, 8, -1);
    out_ready = 1'b1;
    idle(4);
    check("same_cycle_count", 70'(acc_q.size()), 70'(2));
    if (acc_q.size() >= 2) begin
      r = acc_q.pop_front();
      check("same_cycle_first", 70'(r), 70'(m));
      r = acc_q.pop_front();
      check("same_cycle_second", 70'(r), 70'(m2));
    end
    acc_q.delete();
    check("same_cycle_no_ovr", 70'(ovr_cnt - ovr_base), 70'(0));
    $display("[TB] same-cycle accept sequence done");

    // Reset during word 5
    ovr_base = ovr_cnt;
    for (int i = 0; i < 4; i++) send_word(1'b0, 8'h3C, 1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    check("midrst_valid", 70'(out_valid), 70'(0));
    sin   = 1'b1;
    rst_n = 1'b1;
    tick();
    m = model(64'hCAFEBABE_00C0FFEE, 3'b101, 4'h0, 8, -1);
    send_frame(64'hCAFEBABE_00C0FFEE, 3'b101, 4'h0, 8, -1);
    idle(30);
    check("midrst_count", 70'(acc_q.size()), 70'(1));
    if (acc_q.size() >= 1) begin
      r = acc_q.pop_front();
      check("midrst_frame", 70'(r), 70'(m));
    end
    acc_q.delete();
    check("midrst_no_ovr", 70'(ovr_cnt - ovr_base), 70'(0));
    $display("[TB] mid-frame reset sequence done");

    // sin stuck low for five word times, then a control word
    sin = 1'b0;
    repeat (55) tick();
    send_word(1'b1, {1'b0, 3'b100, 4'h0}, 1'b1);
    sin = 1'b1;
    get_result("stuck_pop", r, ok);
    if (ok) begin
      $display("[TB] stuck-low frame err=%b", r.err);
      check("stuck_err", 70'(r.err), 70'(3'b100));
      check("stuck_ba", 70'({r.b, r.a}), 70'(0));
      check("stuck_op", 70'(r.op), 70'(3'b100));
    end
    idle(2);

`ifdef ALU_RX_TIMEOUT_EN
    // Three words then silence past the timeout
    for (int i = 0; i < 3; i++) send_word(1'b0, 8'h41 + 8'(i), 1'b1);
    idle(TO + 1);
    get_result("timeout_pop", r, ok);
    if (ok) begin
      $display("[TB] timeout frame err=%b a=%h", r.err, r.a);
      check("timeout_err", 70'(r.err), 70'(3'b100));
      check("timeout_a", 70'(r.a), 70'(32'h00414243));
    end
    idle(2);
`else
    // Without the timeout a partial frame simply waits
    for (int i = 0; i < 3; i++) send_word(1'b0, 8'h41 + 8'(i), 1'b1);
    idle(TO + 40);
    check("no_timeout_idle", 70'({acc_q.size() != 0, out_valid}), 70'(0));
    $display("[TB] partial frame kept waiting");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle(2);
`endif

    // Random frames against the model
    exp_q.delete();
    acc_q.delete();
    for (int k = 0; k < 30; k++) begin
      ba   = {$urandom, $urandom};
      op   = 3'($urandom_range(0, 7));
      flip = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      n    = ($urandom_range(0, 5) == 0) ? int'($urandom_range(7, 9)) : 8;
      bad  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : -1;
      exp_q.push_back(model(ba, op, flip, n, bad));
      send_frame(ba, op, flip, n, bad);
      idle($urandom_range(0, 2));
    end
    idle(20);
    n_acc = acc_q.size();
    check("rand_count", 70'(n_acc), 70'(30));
    for (int k = 0; k < 30 && k < n_acc; k++) begin
      r = acc_q[k];
      $display("[TB] rand %0d b=%h a=%h op=%b err=%b", k, r.b, r.a, r.op, r.err);
      check($sformatf("rand%0d", k), 70'(r), 70'(exp_q[k]));
    end

    check("total_overruns", 70'(ovr_cnt), 70'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_serial_rx.md
# alu_serial_rx

Serial input deserializer for the ALU datapath: samples the single-bit `sin` line, assembles 11-bit words into a 9-word command frame (4 bytes B, 4 bytes A, 1 control byte), checks framing, CRC4 and opcode, and presents a parallel command to the ALU core over a valid/ready handshake. It sits directly between the serial pin and the ALU arithmetic core, producing the operands and error flags the core and output serializer consume.

## Interface
- `TIMEOUT_CYCLES`, 64, max idle cycles between words inside a frame (used only with `ALU_RX_TIMEOUT_EN`)
- `clk` in 1: single clock, all state on rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `sin` in 1: serial input, idle high, one bit per clock
- `out_ready` in 1: ALU core accepts command
- `out_valid` out 1: command/flags valid
- `out_b` out 32: operand B
- `out_a` out 32: operand A
- `out_op` out 3: opcode
- `out_err` out 3: {ERR_DATA, ERR_CRC, ERR_OP}
- `overrun` out 1: one-cycle pulse, completed frame dropped

## Operation
- Word: start `0`, type bit (`0` data, `1` control), 8 payload bits MSB first, stop `1`.
- Frame: data words accumulate MSB-first into a 64-bit shadow {B,A} (first word = B[31:24]); a control word `{0, op[2:0], crc[3:0]}` terminates the frame.
- States: IDLE (wait `sin`=0) → TYPE → DATA (8 bits, 3-bit counter) → STOP → IDLE, or → CHECK after a control word's stop bit.
- Data-word counter 4 bits, saturates at 9.
- Checks in CHECK, priority ERR_DATA > ERR_CRC > ERR_OP; exactly one flag set, or none:
  - ERR_DATA: data-word count ≠ 8, or any stop bit in the frame sampled `0`.
  - ERR_CRC: received crc ≠ CRC4 over the 68-bit vector {B,A,1'b1,op}, polynomial x^4+x+1, init `0000`.
  - ERR_OP: op not in {000 AND, 001 OR, 100 ADD, 101 SUB}.
- On any error, `out_a`/`out_b`/`out_op` carry the received (possibly partial) values; the core must ignore them.
- Output register loads from shadow in CHECK; shadow and counters clear for the next frame.
- Handshake: `out_valid` holds, with all outputs stable, until the cycle `out_valid && out_ready`; it deasserts on the following edge.
- Receiver keeps deserializing while `out_valid` is high. If CHECK occurs while `out_valid` is still high and not being accepted that cycle, the new frame is dropped, `overrun` pulses one cycle, and the held output is unchanged. Acceptance in the same cycle as CHECK loads the new frame (no drop).

## Timing
- Reset: `out_valid`=0, `out_b`=0, `out_a`=0, `out_op`=000, `out_err`=000, `overrun`=0, FSM in IDLE, counters 0.
- Word occupies 11 cycles; a start bit is accepted the cycle immediately after a stop bit.
- Latency: `out_valid` asserts on the 1st rising edge after the edge that samples the control word's stop bit.
- Reset mid-frame: partial frame is discarded, no `out_valid`, no `overrun`.
- `sin` held `0` indefinitely: decoded as words of type 0, payload 00, bad stop → ERR_DATA once a control word arrives.

## Configuration
- `ALU_RX_TIMEOUT_EN` defined: an inter-word idle counter runs whenever at least one word of the current frame has been received. If it exceeds `TIMEOUT_CYCLES` before the next start bit, the frame is aborted and reported with `out_valid`=1 and `out_err`=100 via the normal handshake/overrun rules. The counter resets on every start bit.
- Not defined: no counter; a partial frame waits indefinitely. `TIMEOUT_CYCLES` is unused.

## Test plan
- B=0x00000005, A=0x00000003, op=100, correct CRC → `out_valid` 1 cycle after last stop; B/A/op match; `out_err`=000.
- Same frame with the CRC bit0 flipped → `out_err`=010.
- Op=111 with CRC computed over op=111 → `out_err`=001.
- 7 data words then a control word; separately 9 data words then a control word → `out_err`=100 in both.
- Hold `out_ready`=0, send two valid frames → first held unchanged, `overrun` pulses once at second CHECK; set `out_ready`=1 → `out_valid` drops the next cycle.
- Assert `rst_n`=0 during word 5, release, send a valid frame → single `out_valid` with the new frame; with `ALU_RX_TIMEOUT_EN`, stop after 3 words for `TIMEOUT_CYCLES`+1 cycles → `out_err`=100.
